ctrl_sequencer: RTL
===================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8, meaning the maximum cycles to wait for a memory ack before entering ERR.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching.
- opcode  in  4  instruction register bits [15:12].
- zero  in  1  ALU zero flag, used by BEQ.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  instruction register write strobe.
- pc_inc  out  1  increment PC.
- pc_load  out  1  load PC from jump target.
- alu_op  out  4  ALU operation code.
- rf_we  out  1  register file write enable.
- wb_sel  out  2  write-back source: 00 ALU, 01 immediate, 10 dmem.
- dmem_re  out  1  data memory read request.
- dmem_we  out  1  data memory write request.
- busy  out  1  high in any state other than IDLE, HALT or ERR.
- halted  out  1  high in HALT.
- err  out  1  high in ERR.

Function
REQ-003 The state machine SHALL have states IDLE, FETCH, LOAD, DECODE, EXEC, MEM, WB, HALT and ERR, all outputs being Moore except where stated.
REQ-004 IDLE SHALL move to FETCH on start=1; start SHALL be ignored in every other state.
REQ-005 FETCH SHALL hold imem_req=1 and move to LOAD in the cycle imem_ack=1 is sampled, including the first FETCH cycle.
REQ-006 LOAD SHALL assert ir_we=1 and pc_inc=1 for exactly one cycle and then move to DECODE.
REQ-007 DECODE SHALL latch opcode into an internal register and then move to EXEC; later changes to the opcode input SHALL not affect the current instruction.
REQ-008 EXEC SHALL act on the latched opcode as follows:
- 0x0 NOP: go to FETCH.
- 0x1 to 0x5 (ADD, SUB, AND, OR, XOR): alu_op = opcode, then WB with wb_sel=00.
- 0x6 LDI: WB with wb_sel=01.
- 0x7 LD and 0x8 ST: go to MEM.
- 0x9 JMP: pc_load=1 for one cycle, then FETCH.
- 0xA BEQ: pc_load=zero for one cycle, then FETCH.
- 0xF: go to HALT.
- 0xB to 0xE: go to ERR.
REQ-009 MEM SHALL hold dmem_re=1 for LD or dmem_we=1 for ST until dmem_ack=1 is sampled; LD SHALL then go to WB with wb_sel=10 and ST to FETCH.
REQ-010 WB SHALL assert rf_we=1 for exactly one cycle, with wb_sel held stable, and then move to FETCH.
REQ-011 alu_op and wb_sel SHALL hold their values from EXEC through WB; all other strobes SHALL be 0 outside their named states.
REQ-012 A timeout counter SHALL clear on entry to FETCH or MEM; if TIMEOUT cycles pass without an ack, the block SHALL go to ERR and drop its request.
REQ-013 imem_ack and dmem_ack SHALL be ignored outside FETCH and MEM respectively.
REQ-014 Minimum latency SHALL be 5 cycles for an ALU instruction, 4 for NOP/JMP/BEQ, and 6 for LD, each with zero-wait acks.
REQ-015 HALT and ERR SHALL be sticky until reset.

Reset
REQ-016 rst=0 SHALL immediately force IDLE, clear all outputs to 0, and clear the opcode latch and timeout counter, including mid-instruction.
REQ-017 After rst is released, the block SHALL act only on a rising clk edge on which start=1.

Structure
REQ-018 Package ctrl_pkg SHALL hold the opcode constants, the state encoding, the wb_sel codes and the default TIMEOUT.
REQ-019 The timeout counter SHALL be the single sub-module ctrl_timer, with inputs clear and enable and output expired.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, start=1, opcode=0x1, imem_ack immediate -> ir_we at cycle 2, rf_we at cycle 5 with alu_op=0x1 and wb_sel=00, back in FETCH at cycle 6.
- LD with dmem_ack delayed 3 cycles -> dmem_re high for 4 cycles, then rf_we with wb_sel=10.
- BEQ with zero=1, then BEQ with zero=0 -> pc_load pulses once for the first and never for the second.
- imem_ack never asserted, TIMEOUT=8 -> err=1 after 8 FETCH cycles, imem_req=0, and ERR held.
- opcode=0xC -> err=1; opcode=0xF -> halted=1, busy=0, and start ignored.
- rst=0 asserted mid-MEM -> all outputs 0 immediately; after release, remains in IDLE until start.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, state encoding and write-back codes for the control sequencer
package ctrl_pkg;

  localparam int DEFAULT_TIMEOUT = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERR
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] wb_sel_for(input logic [3:0] op);
    case (op)
      OP_LDI:  return WB_IMM;
      OP_LD:   return WB_MEM;
      default: return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_timer.sv
// rtl/ctrl_timer.sv - ack-wait timeout counter; expired flags the TIMEOUT-th waiting cycle
module ctrl_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q;

  assign expired = (count_q == CW'(TIMEOUT - 1));

  // Saturates at the expiry value so a stalled enable never wraps back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - multi-cycle instruction sequencer: fetch, decode, execute, memory, write-back
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [3:0] alu_op,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       dmem_re,
  output logic       dmem_we,
  output logic       busy,
  output logic       halted,
  output logic       err
);

  state_e     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;
  logic       imem_req_q, imem_req_d;
  logic       ir_we_q, ir_we_d;
  logic       pc_load_q, pc_load_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic       rf_we_q, rf_we_d;
  logic [1:0] wb_sel_q, wb_sel_d;
  logic       dmem_re_q, dmem_re_d;
  logic       dmem_we_q, dmem_we_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       err_q, err_d;

  logic timer_clear, timer_enable, timer_expired;

  assign timer_enable = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timer_clear  = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q);

  ctrl_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)           state_d = ST_LOAD;
        else if (timer_expired) state_d = ST_ERR;
      end
      ST_LOAD:   state_d = ST_DECODE;
      ST_DECODE: begin
        opcode_d = opcode;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode_q)
          OP_NOP, OP_JMP, OP_BEQ:                       state_d = ST_FETCH;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: state_d = ST_WB;
          OP_LD, OP_ST:                                 state_d = ST_MEM;
          OP_HALT:                                      state_d = ST_HALT;
          default:                                      state_d = ST_ERR;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack)           state_d = (opcode_q == OP_LD) ? ST_WB : ST_FETCH;
        else if (timer_expired) state_d = ST_ERR;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    imem_req_d = (state_d == ST_FETCH);
    ir_we_d    = (state_d == ST_LOAD);
    rf_we_d    = (state_d == ST_WB);
    dmem_re_d  = (state_d == ST_MEM) && (opcode_d == OP_LD);
    dmem_we_d  = (state_d == ST_MEM) && (opcode_d == OP_ST);
    pc_load_d  = (state_d == ST_EXEC) &&
                 ((opcode_d == OP_JMP) || ((opcode_d == OP_BEQ) && zero));
    busy_d     = !((state_d == ST_IDLE) || (state_d == ST_HALT) || (state_d == ST_ERR));
    halted_d   = (state_d == ST_HALT);
    err_d      = (state_d == ST_ERR);
    alu_op_d   = 4'h0;
    wb_sel_d   = WB_ALU;
    if (state_d == ST_EXEC) begin
      alu_op_d = is_alu_op(opcode_d) ? opcode_d : 4'h0;
      wb_sel_d = wb_sel_for(opcode_d);
    end else if ((state_d == ST_MEM) || (state_d == ST_WB)) begin
      alu_op_d = alu_op_q;
      wb_sel_d = wb_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      opcode_q   <= 4'h0;
      imem_req_q <= 1'b0;
      ir_we_q    <= 1'b0;
      pc_load_q  <= 1'b0;
      alu_op_q   <= 4'h0;
      rf_we_q    <= 1'b0;
      wb_sel_q   <= WB_ALU;
      dmem_re_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      imem_req_q <= imem_req_d;
      ir_we_q    <= ir_we_d;
      pc_load_q  <= pc_load_d;
      alu_op_q   <= alu_op_d;
      rf_we_q    <= rf_we_d;
      wb_sel_q   <= wb_sel_d;
      dmem_re_q  <= dmem_re_d;
      dmem_we_q  <= dmem_we_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  assign imem_req = imem_req_q;
  assign ir_we    = ir_we_q;
  assign pc_inc   = ir_we_q;
  assign pc_load  = pc_load_q;
  assign alu_op   = alu_op_q;
  assign rf_we    = rf_we_q;
  assign wb_sel   = wb_sel_q;
  assign dmem_re  = dmem_re_q;
  assign dmem_we  = dmem_we_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign err      = err_q;

endmodule
